// File: rtl/motor_model_pwm_pkg.sv
// -----------------------------------------------------------------------------
// motor_model_pwm_pkg
// Shared types and constants for the three-phase PWM dead-time stage.
//   phase_state_t : per-phase gate FSM state (OFF, HIGH_ON, LOW_ON, DEAD)
//   P_NUM_PHASES  : number of bridge legs
//   PH_U/PH_V/PH_W: leg indices used for the per-phase vectors
// -----------------------------------------------------------------------------
package motor_model_pwm_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    HIGH_ON = 2'd1,
    LOW_ON  = 2'd2,
    DEAD    = 2'd3
  } phase_state_t;

  localparam int P_NUM_PHASES = 3;
  localparam int PH_U         = 0;
  localparam int PH_V         = 1;
  localparam int PH_W         = 2;

endpackage

// File: rtl/motor_model_pwm_deadtime_phase.sv
// -----------------------------------------------------------------------------
// motor_model_pwm_deadtime_phase
// One bridge leg: gate FSM with dead-time countdown and registered drives.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_run          : leg may conduct; low forces OFF in one cycle
//   i_pwm          : raw command, 1 = high side, 0 = low side
//   i_dead_time    : dead interval in cycles (0 behaves as 1)
//   o_h, o_l       : registered high/low gate drives
//   o_dead         : registered, high while the leg is in DEAD
// -----------------------------------------------------------------------------
module motor_model_pwm_deadtime_phase
  import motor_model_pwm_pkg::*;
#(
  parameter int P_DT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_run,
  input  logic                  i_pwm,
  input  logic [P_DT_WIDTH-1:0] i_dead_time,
  output logic                  o_h,
  output logic                  o_l,
  output logic                  o_dead
);

  localparam logic [P_DT_WIDTH-1:0] L_ONE = P_DT_WIDTH'(1);

  phase_state_t          r_state;
  logic                  r_target;
  logic [P_DT_WIDTH-1:0] r_cnt;
  logic [P_DT_WIDTH-1:0] w_load;

  // A zero dead time still yields one both-off cycle.
  assign w_load = (i_dead_time == '0) ? L_ONE : i_dead_time;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= OFF;
      r_target <= 1'b0;
      r_cnt    <= '0;
      o_h      <= 1'b0;
      o_l      <= 1'b0;
      o_dead   <= 1'b0;
    end else if (!i_run) begin
      // Immediate shutdown, no dead interval needed when both sides go off.
      r_state <= OFF;
      r_cnt   <= '0;
      o_h     <= 1'b0;
      o_l     <= 1'b0;
      o_dead  <= 1'b0;
    end else begin
      case (r_state)
        OFF: begin
          r_state  <= DEAD;
          r_target <= i_pwm;
          r_cnt    <= w_load;
          o_dead   <= 1'b1;
        end
        HIGH_ON: begin
          if (!i_pwm) begin
            r_state  <= DEAD;
            r_target <= 1'b0;
            r_cnt    <= w_load;
            o_h      <= 1'b0;
            o_dead   <= 1'b1;
          end
        end
        LOW_ON: begin
          if (i_pwm) begin
            r_state  <= DEAD;
            r_target <= 1'b1;
            r_cnt    <= w_load;
            o_l      <= 1'b0;
            o_dead   <= 1'b1;
          end
        end
        DEAD: begin
          // A command reversal restarts the full interval; it takes priority
          // over expiry so the old target never gets a one-cycle pulse.
          if (i_pwm != r_target) begin
            r_target <= i_pwm;
            r_cnt    <= w_load;
          end else if (r_cnt <= L_ONE) begin
            r_state <= r_target ? HIGH_ON : LOW_ON;
            o_h     <= r_target;
            o_l     <= ~r_target;
            o_dead  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        default: begin
          r_state <= OFF;
          o_h     <= 1'b0;
          o_l     <= 1'b0;
          o_dead  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/motor_model_pwm_deadtime.sv
// -----------------------------------------------------------------------------
// motor_model_pwm_deadtime
// Three-phase gate-drive stage with programmable dead time.
// Optional feature macro: MOTOR_MODEL_PWM_SHOOT_THROUGH_CHECK_EN
//   defined   : sticky shoot-through checker drives o_fault
//   undefined : o_fault tied 0, i_fault_clr ignored
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   i_pwm_u/v/w                 : raw phase commands
//   i_dead_time                 : dead time in cycles (0 behaves as 1)
//   i_enable, i_powerdown_n     : bridge enable, safety powerdown (active low)
//   i_fault_clr                 : pulse clearing the sticky fault
//   o_u/v/w_h, o_u/v/w_l        : registered gate drives
//   o_fault                     : sticky shoot-through fault
//   o_dead_active[2:0]          : per-phase dead flag, bit 0 = U
// -----------------------------------------------------------------------------
module motor_model_pwm_deadtime
  import motor_model_pwm_pkg::*;
#(
  parameter int P_DT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pwm_u,
  input  logic                  i_pwm_v,
  input  logic                  i_pwm_w,
  input  logic [P_DT_WIDTH-1:0] i_dead_time,
  input  logic                  i_enable,
  input  logic                  i_powerdown_n,
  input  logic                  i_fault_clr,
  output logic                  o_u_h,
  output logic                  o_v_h,
  output logic                  o_w_h,
  output logic                  o_u_l,
  output logic                  o_v_l,
  output logic                  o_w_l,
  output logic                  o_fault,
  output logic [2:0]            o_dead_active
);

  logic                    w_run;
  logic [P_NUM_PHASES-1:0] w_pwm;
  logic [P_NUM_PHASES-1:0] w_h;
  logic [P_NUM_PHASES-1:0] w_l;
  logic [P_NUM_PHASES-1:0] w_dead;

  assign w_run = i_enable & i_powerdown_n & ~o_fault;

  assign w_pwm[PH_U] = i_pwm_u;
  assign w_pwm[PH_V] = i_pwm_v;
  assign w_pwm[PH_W] = i_pwm_w;

  for (genvar gi = 0; gi < P_NUM_PHASES; gi++) begin : g_phase
    motor_model_pwm_deadtime_phase #(
      .P_DT_WIDTH (P_DT_WIDTH)
    ) u_phase (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_run       (w_run),
      .i_pwm       (w_pwm[gi]),
      .i_dead_time (i_dead_time),
      .o_h         (w_h[gi]),
      .o_l         (w_l[gi]),
      .o_dead      (w_dead[gi])
    );
  end

  assign o_u_h         = w_h[PH_U];
  assign o_v_h         = w_h[PH_V];
  assign o_w_h         = w_h[PH_W];
  assign o_u_l         = w_l[PH_U];
  assign o_v_l         = w_l[PH_V];
  assign o_w_l         = w_l[PH_W];
  assign o_dead_active = w_dead;

`ifdef MOTOR_MODEL_PWM_SHOOT_THROUGH_CHECK_EN
  logic r_fault;
  logic w_violation;

  // Watches the output ports themselves so it is independent of the FSMs.
  assign w_violation = (o_u_h & o_u_l) | (o_v_h & o_v_l) | (o_w_h & o_w_l);

  // A violation in the clear cycle wins, keeping the fault set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= w_violation | (r_fault & ~i_fault_clr);
    end
  end

  assign o_fault = r_fault;
`else
  logic w_unused_fault_clr;
  assign w_unused_fault_clr = i_fault_clr;
  assign o_fault            = 1'b0;
`endif

endmodule

// File: tb/tb_motor_model_pwm_deadtime.sv
module tb_motor_model_pwm_deadtime;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pwm_u, pwm_v, pwm_w;
  logic [7:0] dt;
  logic       en, pd_n, fclr;
  logic       o_u_h, o_v_h, o_w_h, o_u_l, o_v_l, o_w_l, o_fault;
  logic [2:0] o_dead_active;

  int checks = 0;
  int errors = 0;
  bit hold   = 1'b0;
  bit inject = 1'b0;

  motor_model_pwm_deadtime #(.P_DT_WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_pwm_u       (pwm_u),
    .i_pwm_v       (pwm_v),
    .i_pwm_w       (pwm_w),
    .i_dead_time   (dt),
    .i_enable      (en),
    .i_powerdown_n (pd_n),
    .i_fault_clr   (fclr),
    .o_u_h         (o_u_h),
    .o_v_h         (o_v_h),
    .o_w_h         (o_w_h),
    .o_u_l         (o_u_l),
    .o_v_l         (o_v_l),
    .o_w_l         (o_w_l),
    .o_fault       (o_fault),
    .o_dead_active (o_dead_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each leg: side currently conducting (0 none, 1 high, 2 low), side being
  // waited for, and the absolute cycle at which that wait ends.
  int     m_side[3];
  int     m_pend[3];
  longint m_end[3];
  longint cyc;
  bit     m_fault;

  always @(posedge clk or negedge rst_n) begin
    bit       run;
    int       dd;
    int       want;
    bit [2:0] cmd;
    if (!rst_n) begin
      for (int p = 0; p < 3; p++) begin
        m_side[p] = 0; m_pend[p] = 0; m_end[p] = 0;
      end
      cyc = 0;
      m_fault = 1'b0;
    end else begin
      cyc++;
      cmd = {pwm_w, pwm_v, pwm_u};
      run = en && pd_n && !m_fault;
      dd  = (dt == 0) ? 1 : int'(dt);
      for (int p = 0; p < 3; p++) begin
        want = cmd[p] ? 1 : 2;
        if (!run) begin
          m_side[p] = 0; m_pend[p] = 0;
        end else if (m_pend[p] != 0) begin
          if (want != m_pend[p]) begin
            m_pend[p] = want; m_end[p] = cyc + dd;
          end else if (cyc == m_end[p]) begin
            m_side[p] = m_pend[p]; m_pend[p] = 0;
          end
        end else if (m_side[p] != want) begin
          m_side[p] = 0; m_pend[p] = want; m_end[p] = cyc + dd;
        end
      end
`ifdef MOTOR_MODEL_PWM_SHOOT_THROUGH_CHECK_EN
      m_fault = inject || (m_fault && !fclr);
`else
      m_fault = 1'b0;
`endif
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [9:0] exp_v, act_v;
    if (!hold) begin
      for (int p = 0; p < 3; p++) begin
        exp_v[p]     = (m_side[p] == 1);
        exp_v[3 + p] = (m_side[p] == 2);
        exp_v[6 + p] = (m_pend[p] != 0);
      end
      exp_v[9] = m_fault;
      act_v = {o_fault, o_dead_active, o_w_l, o_v_l, o_u_l, o_w_h, o_v_h, o_u_h};
      chk("model_cmp{flt,dead,l,h}", 32'(act_v), 32'(exp_v));
    end
  end

  // ---------------- helpers ----------------
  function automatic logic get_h(input int ph);
    return (ph == 0) ? o_u_h : (ph == 1) ? o_v_h : o_w_h;
  endfunction
  function automatic logic get_l(input int ph);
    return (ph == 0) ? o_u_l : (ph == 1) ? o_v_l : o_w_l;
  endfunction
  task automatic set_cmd(input int ph, input logic v);
    if (ph == 0) pwm_u = v; else if (ph == 1) pwm_v = v; else pwm_w = v;
  endtask

  // Drive a command change at a falling edge and measure the both-off span.
  task automatic switchover(input int ph, input logic newcmd, input int exp_off, input string nm);
    int off = 0, dact = 0;
    bit reached = 1'b0;
    @(negedge clk);
    set_cmd(ph, newcmd);
    for (int n = 0; n < 60 && !reached; n++) begin
      @(negedge clk);
      if (!get_h(ph) && !get_l(ph)) off++;
      if (o_dead_active[ph]) dact++;
      if ((newcmd && get_h(ph)) || (!newcmd && get_l(ph))) reached = 1'b1;
    end
    chk({nm, "_reached"}, 32'(reached), 32'd1);
    chk({nm, "_off_cycles"}, off, exp_off);
    chk({nm, "_dead_cycles"}, dact, exp_off);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  off;
    bit  reached, changed;
    rst_n = 1'b0; en = 1'b1; pd_n = 1'b1; fclr = 1'b0;
    pwm_u = 1'b1; pwm_v = 1'b0; pwm_w = 1'b0; dt = 8'd4;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({o_fault, o_dead_active, o_u_h, o_v_h, o_w_h, o_u_l, o_v_l, o_w_l}), 32'd0);
    rst_n = 1'b1;

    // Power-up with D=4: U high 4 edges after the first sampling edge.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t1_u_h_low", 32'(o_u_h), 32'd0);
      chk("t1_u_l_low", 32'(o_u_l), 32'd0);
      chk("t1_u_dead", 32'(o_dead_active[0]), 32'd1);
    end
    @(posedge clk); #1;
    chk("t1_u_h_on", 32'(o_u_h), 32'd1);
    chk("t1_u_l_off", 32'(o_u_l), 32'd0);
    chk("t1_v_l_on", 32'(o_v_l), 32'd1);

    // D=3 toggling on V.
    @(negedge clk); dt = 8'd3;
    repeat (5) @(negedge clk);
    switchover(1, 1'b1, 3, "t2_v_rise");
    repeat (16) @(negedge clk);
    switchover(1, 1'b0, 3, "t2_v_fall");
    repeat (16) @(negedge clk);
    switchover(1, 1'b1, 3, "t2_v_rise2");

    // D=6, reverse in 3rd dead cycle with D=2: 5 both-off cycles total.
    @(negedge clk); dt = 8'd6;
    repeat (3) @(negedge clk);
    pwm_u = 1'b0;
    off = 0; reached = 0; changed = 0;
    for (int n = 0; n < 60 && !reached; n++) begin
      @(negedge clk);
      if (!o_u_h && !o_u_l) off++;
      if (off == 3 && !changed) begin
        dt = 8'd2; pwm_u = 1'b1; changed = 1'b1;
      end
      if (o_u_h) reached = 1'b1;
    end
    chk("t3_reached", 32'(reached), 32'd1);
    chk("t3_off_cycles", off, 5);

    // Single-cycle powerdown with D=4.
    dt = 8'd4;
    repeat (10) @(negedge clk);
    pd_n = 1'b0;
    @(negedge clk);
    pd_n = 1'b1;
    chk("t4_all_off", 32'({o_u_h, o_v_h, o_w_h, o_u_l, o_v_l, o_w_l, o_dead_active}), 32'd0);
    off = 1; reached = 0;
    for (int n = 0; n < 60 && !reached; n++) begin
      @(negedge clk);
      if (o_u_h) reached = 1'b1; else off++;
    end
    chk("t4_reached", 32'(reached), 32'd1);
    chk("t4_off_cycles", off, 5);

    // D=0 behaves as 1.
    dt = 8'd0;
    repeat (3) @(negedge clk);
    switchover(2, 1'b1, 1, "t5_w_rise");
    repeat (5) @(negedge clk);
    switchover(2, 1'b0, 1, "t5_w_fall");

    // Enable drop with a simultaneous command change: run wins.
    dt = 8'd3;
    repeat (6) @(negedge clk);
    en = 1'b0; pwm_v = ~pwm_v;
    @(negedge clk);
    chk("t6_en_off", 32'({o_u_h, o_v_h, o_w_h, o_u_l, o_v_l, o_w_l, o_dead_active}), 32'd0);
    en = 1'b1;
    repeat (8) @(negedge clk);

    // Asynchronous reset in the middle of an interval.
    dt = 8'd5;
    pwm_u = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t7_async_rst", 32'({o_u_h, o_v_h, o_w_h, o_u_l, o_v_l, o_w_l, o_dead_active}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    // Fault clear pulse: no effect unless a fault was latched.
    fclr = 1'b1;
    @(negedge clk);
    fclr = 1'b0;
    repeat (3) @(negedge clk);

`ifdef MOTOR_MODEL_PWM_SHOOT_THROUGH_CHECK_EN
    dt = 8'd3;
    repeat (8) @(negedge clk);
    hold = 1'b1; inject = 1'b1;
    force dut.o_w_h = 1'b1;
    force dut.o_w_l = 1'b1;
    @(negedge clk);
    release dut.o_w_h;
    release dut.o_w_l;
    inject = 1'b0;
    chk("t8_fault_set", 32'(o_fault), 32'd1);
    @(negedge clk);
    hold = 1'b0;
    chk("t8_fault_off", 32'({o_u_h, o_v_h, o_w_h, o_u_l, o_v_l, o_w_l}), 32'd0);
    repeat (5) @(negedge clk);
    chk("t8_fault_sticky", 32'({o_fault, o_u_h, o_v_h, o_w_h, o_u_l, o_v_l, o_w_l}), 32'h40);
    fclr = 1'b1;
    @(negedge clk);
    fclr = 1'b0;
    chk("t8_fault_clr", 32'(o_fault), 32'd0);
    off = 1; reached = 0;
    for (int n = 0; n < 60 && !reached; n++) begin
      @(negedge clk);
      if (o_u_h || o_u_l) reached = 1'b1; else off++;
    end
    chk("t8_restored", 32'(reached), 32'd1);
    chk("t8_off_cycles", off, 4);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
